serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder controller. It accepts two operands and a carry-in on a start pulse, then sequences one full-add per clock through a single 1-bit adder cell built from two half adders.
- It reports sum and carry-out with a done pulse.
- It sits between a requesting unit (CPU datapath or test sequencer) and the shared 1-bit add cell, trading latency for area.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only when ready=1
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- cin  input  1  carry-in; sampled with start
- ready  output  1  controller can accept start (IDLE or DONE)
- busy  output  1  addition in progress (SHIFT)
- done  output  1  one-cycle pulse; sum/cout valid
- sum  output  WIDTH  result; held until next accepted start
- cout  output  1  final carry; held with sum

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). On rst_n=0, immediately: state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, counter=0, internal shift/carry registers=0.
- States:
  - IDLE: ready=1. start=1 -> latch a, b and carry<=cin; clear counter and sum shift register; go to SHIFT.
  - SHIFT: busy=1, ready=0. Each cycle the adder cell computes:
    - s = a_sh[0]^b_sh[0]^carry
    - c = (a_sh[0]&b_sh[0]) | (carry&(a_sh[0]^b_sh[0]))
    - s shifts into sum_sh MSB; carry<=c; a_sh and b_sh shift right; counter++.
    - When counter==WIDTH-1 (the last bit this cycle), go to DONE.
  - DONE: done=1 for exactly this cycle, ready=1. start=1 -> same action as IDLE, next state SHIFT. Otherwise go to IDLE.
- Latency: start sampled at edge k; busy high for edges k+1..k+WIDTH; done high during the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after start. Throughput: one add per WIDTH+1 cycles.
- Outputs:
  - sum and cout are registered and update only on the transition into DONE: sum<=final sum_sh, cout<=final carry.
  - Between operations they hold their last result.
  - They are not updated incrementally while busy.
- start while busy=1 is ignored; it is not queued and a/b/cin changes are ignored.
- Operand changes after the start sample have no effect.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- rst_n asserted mid-SHIFT: the operation is abandoned, no done pulse, and outputs return to the reset values above.
- ready and busy are mutually exclusive; done implies ready.
- The counter never exceeds WIDTH-1.

Decomposition:
- Shared include/package holds:
  - State encoding localparams: S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2.
  - Encoding 2'd3 is unreachable; the FSM default maps it to S_IDLE.
- One sub-module: serial_fa_cell, a combinational 1-bit full adder built from two half-adder instances plus an OR for carry. The controller instantiates it once.

Test Plan:
- Reset, then start with a=8'h00, b=8'h00, cin=0 -> busy high 8 cycles; done pulses 9 cycles after start; sum=8'h00, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1. Then a=8'h3C, b=8'h42, cin=0 -> sum=8'h7E, cout=0.
- Start a=8'h10, b=8'h20; pulse start with a=8'hFF, b=8'hFF three cycles later while busy -> ignored; result sum=8'h30, cout=0; exactly one done pulse.
- Back-to-back: hold start=1 in the DONE cycle with a=8'h01, b=8'h01 -> first result held; second done exactly 9 cycles later with sum=8'h02; ready never asserted during SHIFT.
- Assert rst_n=0 asynchronously mid-SHIFT (between edges) -> busy=0, ready=1, sum=0, cout=0 immediately; no done pulse; the next start computes correctly.
- Random regression: 1000 random a/b/cin at WIDTH=8 and WIDTH=2 -> {cout,sum} matches the reference a+b+cin on every done.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg
//   Shared definitions for the bit-serial adder controller: FSM state type
//   and the legacy-compatible state encodings. Encoding 2'd3 is never
//   entered; the controller's default branch returns it to S_IDLE.
package serial_adder_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SHIFT = 2'd1;
  localparam state_t S_DONE  = 2'd2;

endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell
//   Combinational 1-bit full adder made of two half adders plus an OR for
//   the carry. This is the single shared add cell the controller sequences.
//   Ports:
//     a, b : operand bits
//     ci   : carry in
//     s    : sum bit
//     co   : carry out
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  serial_ha u_ha0 (
    .x (a),
    .y (b),
    .s (s1),
    .c (c1)
  );

  serial_ha u_ha1 (
    .x (s1),
    .y (ci),
    .s (s),
    .c (c2)
  );

  // The two partial carries are never both 1, so OR completes the full add.
  assign co = c1 | c2;

endmodule

// File: rtl/serial_ha.sv
// serial_ha
//   Combinational 1-bit half adder, the building block of serial_fa_cell.
//   Ports:
//     x, y : addend bits
//     s    : sum bit   (x ^ y)
//     c    : carry bit (x & y)
module serial_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial WIDTH-bit adder controller. On an accepted start it latches
//   a, b and cin, then performs one full-add per clock (LSB first) through a
//   single serial_fa_cell. After WIDTH cycles it registers {cout,sum} and
//   pulses done for one cycle.
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     start  : request pulse, sampled only while ready=1
//     a, b   : operands, sampled with start
//     cin    : carry-in, sampled with start
//     ready  : can accept start (IDLE or DONE)
//     busy   : addition in progress (SHIFT)
//     done   : one-cycle pulse, sum/cout valid
//     sum    : result, held until the next operation completes
//     cout   : final carry, held with sum
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_s;
  logic             fa_c;

  serial_fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  assign ready = (state == S_IDLE) || (state == S_DONE);
  assign busy  = (state == S_SHIFT);
  assign done  = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            cnt    <= '0;
            sum_sh <= '0;
            state  <= S_SHIFT;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          carry  <= fa_c;
          if (cnt == LAST) begin
            // Result is taken from the cell outputs directly so the final
            // bit lands in sum on the same edge as the move to DONE; the
            // counter parks at LAST rather than wrapping.
            sum   <= {fa_s, sum_sh[WIDTH-1:1]};
            cout  <= fa_c;
            state <= S_DONE;
          end else begin
            cnt   <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=2.
//   Expected results come from plain integer addition a+b+cin.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       ready8, busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start2;
  logic [1:0] a2, b2;
  logic       cin2;
  logic       ready2, busy2, done2, cout2;
  logic [1:0] sum2;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .ready (ready8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .cin   (cin2),
    .ready (ready2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned viol = 0;
  int unsigned excl = 0;
  int unsigned done_cnt = 0;
  logic [8:0]  exp8;

  always @(posedge clk) if (done8) done_cnt++;
  always @(negedge clk) begin
    if (ready8 && busy8) excl++;
    if (ready2 && busy2) excl++;
    if (done8 && !ready8) excl++;
    if (done2 && !ready2) excl++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic c);
    start8 = 1'b1;
    a8     = a;
    b8     = b;
    cin8   = c;
    exp8   = {1'b0, a} + {1'b0, b} + {8'd0, c};
    tick;
    start_cyc = cyc;
    start8 = 1'b0;
  endtask

  // Leaves the bench sitting in the done cycle.
  task automatic wait_done(input string tag);
    int unsigned n = 0;
    while (!done8 && n < 40) begin
      if (!busy8 || ready8) viol++;
      tick;
      n++;
    end
    check({tag, "_flags"}, {29'd0, done8, ready8, busy8}, 32'b110);
    check({tag, "_lat"}, cyc - start_cyc, 8);
    check({tag, "_sum"}, {23'd0, cout8, sum8}, {23'd0, exp8});
  endtask

  initial begin
    int unsigned d0;
    logic [2:0]  e2;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    tick;
    tick;
    check("reset", {20'd0, ready8, busy8, done8, cout8, sum8}, {20'd0, 3'b100, 9'h000});
    #2 rst_n = 1'b1;
    tick;

    // Directed patterns
    launch(8'h00, 8'h00, 1'b0); wait_done("zero"); tick;
    check("idle_after", {29'd0, done8, ready8, busy8}, 32'b010);
    launch(8'hFF, 8'h01, 1'b0); wait_done("ff01"); tick;
    launch(8'hA5, 8'h5A, 1'b1); wait_done("a55a"); tick;
    check("a55a_hold", {23'd0, cout8, sum8}, 32'h100);
    launch(8'h3C, 8'h42, 1'b0); wait_done("3c42"); tick;
    check("3c42_hold", {23'd0, cout8, sum8}, 32'h07E);

    // start while busy must be ignored
    launch(8'h10, 8'h20, 1'b0);
    tick; tick;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    tick;
    start8 = 1'b0;
    d0 = done_cnt;
    wait_done("ignore");
    repeat (12) tick;
    check("ignore_one_done", done_cnt - d0, 1);
    check("ignore_hold", {23'd0, cout8, sum8}, 32'h030);

    // Back-to-back: new start in the done cycle
    launch(8'h55, 8'h22, 1'b0); wait_done("b2b_first");
    launch(8'h01, 8'h01, 1'b0);
    check("b2b_hold", {23'd0, cout8, sum8}, 32'h077);
    wait_done("b2b_second");
    tick;

    // Asynchronous reset mid-operation
    launch(8'h12, 8'h34, 1'b0);
    tick; tick;
    #3 rst_n = 1'b0;
    #1;
    check("arst", {20'd0, ready8, busy8, done8, cout8, sum8}, {20'd0, 3'b100, 9'h000});
    d0 = done_cnt;
    #2 rst_n = 1'b1;
    repeat (12) tick;
    check("arst_no_done", done_cnt - d0, 0);
    launch(8'h80, 8'h80, 1'b1); wait_done("post_rst"); tick;

    // Random regression, WIDTH=8 (sometimes back-to-back)
    for (int i = 0; i < 1000; i++) begin
      launch(8'($urandom), 8'($urandom), 1'($urandom));
      wait_done("rnd8");
      if ($urandom_range(1) == 1) tick;
    end
    tick;

    // Random regression, WIDTH=2
    for (int i = 0; i < 1000; i++) begin
      int unsigned s;
      int unsigned n;
      a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
      e2 = {1'b0, a2} + {1'b0, b2} + {2'd0, cin2};
      start2 = 1'b1;
      tick;
      s = cyc;
      start2 = 1'b0;
      n = 0;
      while (!done2 && n < 10) begin
        if (!busy2) viol++;
        tick;
        n++;
      end
      check("rnd2_done", {31'd0, done2}, 1);
      check("rnd2_lat", cyc - s, 2);
      check("rnd2_sum", {29'd0, cout2, sum2}, {29'd0, e2});
      tick;
    end

    check("busy_viol", viol, 0);
    check("excl_viol", excl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
